// File: rtl/lemming_track_env.sv
// Environment model for the lemming walker: tracks position between two configurable walls,
// raises bump_* when the lemming walks into a wall, counts bumps and flags illegal walk codes.
module lemming_track_env #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W     = 4,
  parameter int START_POS = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [POS_W-1:0] cfg_left_wall,
  input  logic [POS_W-1:0] cfg_right_wall,
  output logic             cfg_err,
  output logic             bump_left,
  output logic             bump_right,
  output logic [POS_W-1:0] pos,
  output logic [CNT_W-1:0] bump_count,
  output logic             fault
);

  typedef enum logic {RUN, APPLY} state_t;

  localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
  localparam logic [POS_W-1:0] LAST_P  = POS_W'(TRACK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [POS_W-1:0] lwall_reg, lwall_next;
  logic [POS_W-1:0] rwall_reg, rwall_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             fault_reg, fault_next;
  logic             cfg_err_reg, cfg_err_next;

  logic run, legal, cfg_take, cfg_ok, cfg_load;

  assign run       = (state_reg == RUN);
  assign legal     = walk_left ^ walk_right;
  assign cfg_ready = run && resetn;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_left_wall < cfg_right_wall)
                  && (32'(cfg_right_wall) <= 32'(TRACK_LEN - 1))
                  && (cfg_left_wall <= pos_reg) && (pos_reg <= cfg_right_wall);
  assign cfg_load  = cfg_take && cfg_ok;

  assign bump_left  = resetn && run && legal && walk_left  && (pos_reg == lwall_reg);
  assign bump_right = resetn && run && legal && walk_right && (pos_reg == rwall_reg);

  assign pos        = pos_reg;
  assign bump_count = cnt_reg;
  assign fault      = fault_reg;
  assign cfg_err    = cfg_err_reg;

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    lwall_next   = lwall_reg;
    rwall_next   = rwall_reg;
    cnt_next     = cnt_reg;
    fault_next   = fault_reg;
    cfg_err_next = 1'b0;

    if (run) begin
      if (cfg_take) begin
        if (cfg_ok) begin
          state_next = APPLY;
          lwall_next = cfg_left_wall;
          rwall_next = cfg_right_wall;
        end else begin
          cfg_err_next = 1'b1;
        end
      end
      // Position is held on a load edge so it stays inside the new walls it was checked against.
      if (!legal) begin
        fault_next = 1'b1;
      end else if (!cfg_load) begin
        if (walk_left && (pos_reg > lwall_reg))
          pos_next = pos_reg - 1'b1;
        else if (walk_right && (pos_reg < rwall_reg))
          pos_next = pos_reg + 1'b1;
      end
    end else begin
      state_next = RUN;
    end

    if ((bump_left || bump_right) && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= RUN;
      pos_reg     <= START_P;
      lwall_reg   <= '0;
      rwall_reg   <= LAST_P;
      cnt_reg     <= '0;
      fault_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      lwall_reg   <= lwall_next;
      rwall_reg   <= rwall_next;
      cnt_reg     <= cnt_next;
      fault_reg   <= fault_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

endmodule

// File: tb/tb_lemming_track_env.sv
// Directed bench for lemming_track_env: walker bounce, wall config accept/reject,
// illegal walk codes, reset during APPLY and bump counter saturation.
module tb_lemming_track_env;

  logic       clk = 1'b0;
  logic       resetn;
  logic       walk_left, walk_right;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_left_wall, cfg_right_wall;
  logic       cfg_err;
  logic       bump_left, bump_right;
  logic [3:0] pos;
  logic [7:0] bump_count;
  logic       fault;

  int vectors = 0;
  int miscompares = 0;
  bit auto_walk = 1'b0;

  lemming_track_env #(.TRACK_LEN(16), .POS_W(4), .START_POS(0), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .walk_left(walk_left), .walk_right(walk_right),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_left_wall(cfg_left_wall),
    .cfg_right_wall(cfg_right_wall), .cfg_err(cfg_err), .bump_left(bump_left),
    .bump_right(bump_right), .pos(pos), .bump_count(bump_count), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock; when auto_walk is set, behave like a registered walker that turns on a bump.
  task automatic tick();
    logic bl, br;
    bl = bump_left;
    br = bump_right;
    @(posedge clk);
    #1;
    if (auto_walk && bl) begin walk_left = 1'b0; walk_right = 1'b1; end
    else if (auto_walk && br) begin walk_left = 1'b1; walk_right = 1'b0; end
    #1;
  endtask

  initial begin
    resetn = 1'b0; walk_left = 1'b1; walk_right = 1'b0;
    cfg_valid = 1'b0; cfg_left_wall = '0; cfg_right_wall = '0;
    tick(); tick();

    // Reset state
    chk("rst_pos", pos, 0);
    chk("rst_count", bump_count, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_bump_left", bump_left, 0);

    // T1: full traverse 0 -> 15 with a walker turning on each bump
    resetn = 1'b1; #1;
    chk("t1_bump_left0", bump_left, 1);
    chk("t1_cfg_ready", cfg_ready, 1);
    auto_walk = 1'b1;
    tick();
    chk("t1_count1", bump_count, 1);
    chk("t1_pos0", pos, 0);
    chk("t1_no_bump", bump_left | bump_right, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t1_pos%0d", i), pos, i);
    end
    chk("t1_bump_right", bump_right, 1);
    tick();
    chk("t1_count2", bump_count, 2);
    chk("t1_pos15_hold", pos, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("t1_pos10", pos, 10);

    // T3: pos=10, walls 2/7 rejected; lemming keeps walking left
    cfg_valid = 1'b1; cfg_left_wall = 4'd2; cfg_right_wall = 4'd7;
    tick();
    cfg_valid = 1'b0;
    chk("t3_cfg_err", cfg_err, 1);
    chk("t3_cfg_ready", cfg_ready, 1);
    chk("t3_pos9", pos, 9);
    tick();
    chk("t3_cfg_err_pulse", cfg_err, 0);
    chk("t3_pos8", pos, 8);

    // T2: walls 3/8 accepted at pos 8; one APPLY cycle, then bounce 3<->8
    cfg_valid = 1'b1; cfg_left_wall = 4'd3; cfg_right_wall = 4'd8;
    tick();
    cfg_valid = 1'b0;
    chk("t2_apply_ready", cfg_ready, 0);
    chk("t2_apply_pos", pos, 8);
    chk("t2_apply_bump", bump_left | bump_right, 0);
    chk("t2_no_err", cfg_err, 0);
    tick();
    chk("t2_run_ready", cfg_ready, 1);
    chk("t2_settle_pos", pos, 8);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_pos3", pos, 3);
    chk("t2_bump_left", bump_left, 1);
    chk("t2_count_before", bump_count, 2);
    tick();
    chk("t2_count3", bump_count, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_pos8", pos, 8);
    chk("t2_bump_right", bump_right, 1);
    tick();
    chk("t2_count4", bump_count, 4);

    // T4: illegal walk encoding sets sticky fault, pos holds
    auto_walk = 1'b0;
    walk_left = 1'b1; walk_right = 1'b1; #1;
    chk("t4_bump_both", bump_left | bump_right, 0);
    tick();
    chk("t4_fault", fault, 1);
    chk("t4_pos_hold", pos, 8);
    chk("t4_count_hold", bump_count, 4);
    walk_left = 1'b1; walk_right = 1'b0;
    tick();
    chk("t4_pos7", pos, 7);
    chk("t4_fault_sticky", fault, 1);

    // T6: reset asserted during APPLY drops the pending walls
    cfg_valid = 1'b1; cfg_left_wall = 4'd5; cfg_right_wall = 4'd10;
    tick();
    cfg_valid = 1'b0;
    chk("t6_in_apply", cfg_ready, 0);
    resetn = 1'b0;
    tick();
    chk("t6_pos", pos, 0);
    chk("t6_count", bump_count, 0);
    chk("t6_fault", fault, 0);
    resetn = 1'b1; walk_left = 1'b1; walk_right = 1'b0; #1;
    chk("t6_ready", cfg_ready, 1);
    chk("t6_lwall0_bump", bump_left, 1);

    // Saturation: pushing against the left wall bumps every cycle
    for (int i = 0; i < 254; i++) tick();
    chk("sat_254", bump_count, 254);
    tick();
    chk("sat_255", bump_count, 255);
    for (int i = 0; i < 40; i++) tick();
    chk("sat_hold", bump_count, 255);
    chk("sat_pos", pos, 0);

    // Right wall back to 15 after reset
    walk_left = 1'b0; walk_right = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("rwall15_pos", pos, 15);
    chk("rwall15_bump", bump_right, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
